uart_op_sequencer: RTL
======================

# uart_op_sequencer

Controller between the byte-level UART receiver/transmitter and the compute datapath of the single-cycle CPU system. Collects two consecutive received bytes as an operand pair and hands them to the compute unit over a valid/ready handshake. It then waits for the result and schedules transmission of the result byte. It also holds the last result for LED/digit display, and reports dropped-byte and inter-byte-timeout errors.

## Interface
- `TIMEOUT_CYCLES`, default 2_000_000: max clocks allowed between byte A and byte B (20 ms at 100 MHz).
- `CNT_W`, default 8: width of the completed-transaction counter.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: one-cycle pulse, received byte available.
- `rx_data` in 8: received byte, valid with `rx_valid`.
- `op_valid` out 1: operand pair offered to compute unit.
- `op_ready` in 1: compute unit accepts pair.
- `op_a`, `op_b` out 8 each: operands (A = first byte).
- `res_valid` in 1: one-cycle pulse, result available.
- `res_data` in 8: result byte.
- `tx_ready` in 1: transmitter idle.
- `tx_start` out 1: one-cycle pulse, start sending `tx_data`.
- `tx_data` out 8: byte to transmit.
- `tx_done` in 1: one-cycle pulse, stop bit finished.
- `res_last` out 8: last completed result (display).
- `pair_cnt` out CNT_W: completed transactions, wraps.
- `busy` out 1: state != IDLE.
- `err_overrun` out 1: sticky, a byte arrived while not accepting.
- `err_timeout` out 1: sticky, byte B missed deadline.
- `err_clr` in 1: clears sticky errors.

## Operation
- All outputs reset to 0; state to IDLE; timer to 0.
- IDLE: on `rx_valid`, latch `op_a`=`rx_data`, clear timer, go to WAIT_B.
- WAIT_B: timer increments each cycle.
  - On `rx_valid`: latch `op_b`, go to REQ.
  - Else if timer reaches TIMEOUT_CYCLES-1: set `err_timeout`, go to IDLE; `op_a` is retained but not used.
  - If `rx_valid` arrives in the expiry cycle, the byte wins: it is accepted as B and no error is raised.
- REQ: `op_valid`=1, with `op_a`/`op_b` held stable. On the cycle where `op_ready`=1, the transfer occurs: `op_valid` drops and the state goes to WAIT_RES.
- WAIT_RES: on `res_valid`, latch `tx_data`=`res_last`=`res_data`, go to SEND. Compute latency is unbounded; there is no timeout in this state.
- SEND: `tx_start`=1 for exactly the first cycle in which `tx_ready`=1, then go to WAIT_TX.
- WAIT_TX: on `tx_done`, increment `pair_cnt` (mod 2^CNT_W), go to IDLE.
- `rx_valid` in REQ, WAIT_RES, SEND or WAIT_TX: the byte is dropped and `err_overrun` is set.
- `err_clr` clears both sticky errors. If `err_clr` and a set event occur in the same cycle, set wins.
- `res_valid` or `tx_done` arriving in any state other than its own is ignored.
- Reset mid-transaction aborts immediately: all state, outputs and counters return to 0. The compute unit and transmitter are reset by the same `reset`.

## Timing
- Byte A `rx_valid` at cycle t: `op_a` valid and `busy`=1 from t+1.
- Byte B at cycle u: `op_valid`=1 from u+1. Earliest handshake completes at u+1, giving WAIT_RES at u+2.
- `res_valid` at cycle v: `res_last`/`tx_data` update at v+1, and `tx_start` is earliest at v+1 if `tx_ready`=1.
- `tx_done` at cycle w: `pair_cnt` increments and `busy`=0 at w+1. A new byte A is accepted at w+1.
- Error flags update one cycle after the causing event.

## Structure
- Shared package `uart_seq_pkg`:
  - State encoding localparams: IDLE, WAIT_B, REQ, WAIT_RES, SEND, WAIT_TX (3-bit).
  - Default `TIMEOUT_CYCLES`.
  - `CLK_HZ`=100_000_000.
  - `BIT_CYCLES`=10416 (9600 baud), for bench use.
- One sub-module: `seq_timeout_timer`. It is a clear/enable counter with an `expired` flag at TIMEOUT_CYCLES-1. The FSM, operand, result and error registers stay in the top.

## Test plan
- Bench compute model is GCD; bench sets TIMEOUT_CYCLES=50.
- Bytes 0x3A, 0x57 (58, 87), compute returns after 20 cycles: `op_a`=0x3A, `op_b`=0x57 offered; `tx_data`=`res_last`=0x1D (29); one `tx_start`; `pair_cnt`=1.
- Bytes 0x68, 0x4E (104, 78), with `op_ready` held low for 5 cycles: `op_valid` held with stable operands; result 0x1A (26); `tx_start` deferred until `tx_ready`=1 while `tx_ready`=0 for 10 cycles.
- Byte 0x3A, then no byte for 50 cycles: `err_timeout`=1 and `busy`=0. Next pair 0x11, 0x22 is processed normally, with `op_a`=0x11.
- Extra byte 0x55 during WAIT_RES: `err_overrun`=1 and the result is unaffected. `err_clr` pulse gives 0, except when it coincides with a new overrun, in which case the flag stays 1.
- Reset asserted during REQ: all outputs 0 next edge. A subsequent pair 0x06, 0x04 yields 0x02.
- 256 transactions with CNT_W=8: `pair_cnt` wraps 0xFF to 0x00.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART operand sequencer: state encoding,
// default deadline and clock/baud constants.
package uart_seq_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_B   = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_WAIT_RES = 3'd3;
  localparam logic [2:0] S_SEND     = 3'd4;
  localparam logic [2:0] S_WAIT_TX  = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    WAIT_B   = S_WAIT_B,
    REQ      = S_REQ,
    WAIT_RES = S_WAIT_RES,
    SEND     = S_SEND,
    WAIT_TX  = S_WAIT_TX
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 2_000_000;
  localparam int CLK_HZ                 = 100_000_000;
  localparam int BIT_CYCLES             = 10416;

endpackage

// File: rtl/seq_timeout_timer.sv
// Inter-byte deadline counter: cleared on byte A, counts while enabled,
// flags the last allowed cycle and saturates there.
module seq_timeout_timer
  import uart_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/uart_op_sequencer.sv
// Pairs two received bytes into an operand request, waits for the compute
// result, schedules its transmission and keeps display/error status.
module uart_op_sequencer
  import uart_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [7:0]       op_a,
  output logic [7:0]       op_b,
  input  logic             res_valid,
  input  logic [7:0]       res_data,
  input  logic             tx_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic [7:0]       res_last,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             busy,
  output logic             err_overrun,
  output logic             err_timeout,
  input  logic             err_clr,
  output logic [2:0]       state_dbg
);

  // Handshake: a transfer happens on every clock edge where op_valid and
  // op_ready are both 1; op_valid never drops and op_a/op_b never change
  // while op_valid is 1 and op_ready is 0.
  state_e state;
  logic   expired;
  logic   timeout_hit;
  logic   overrun_hit;

  seq_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     ((state == IDLE) && rx_valid),
    .en      (state == WAIT_B),
    .expired (expired)
  );

  // A byte arriving in the expiry cycle is taken as B, so it masks the timeout.
  assign timeout_hit = (state == WAIT_B) && !rx_valid && expired;
  assign overrun_hit = rx_valid && (state inside {REQ, WAIT_RES, SEND, WAIT_TX});
  assign tx_start    = (state == SEND) && tx_ready;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_valid    <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      tx_data     <= '0;
      res_last    <= '0;
      pair_cnt    <= '0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (overrun_hit)  err_overrun <= 1'b1;
      else if (err_clr) err_overrun <= 1'b0;
      if (timeout_hit)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;

      case (state)
        IDLE: if (rx_valid) begin
          op_a  <= rx_data;
          state <= WAIT_B;
        end
        WAIT_B: if (rx_valid) begin
          op_b     <= rx_data;
          op_valid <= 1'b1;
          state    <= REQ;
        end else if (expired) begin
          state <= IDLE;
        end
        REQ: if (op_ready) begin
          op_valid <= 1'b0;
          state    <= WAIT_RES;
        end
        WAIT_RES: if (res_valid) begin
          tx_data  <= res_data;
          res_last <= res_data;
          state    <= SEND;
        end
        SEND: if (tx_ready) state <= WAIT_TX;
        WAIT_TX: if (tx_done) begin
          pair_cnt <= pair_cnt + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
